vending_credit_ctrl: RTL and testbench



---
 rtl/vending_credit_ctrl.sv | 116 +++++++++++
 tb/tb_vending_credit_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_credit_ctrl.sv
// Credit/settlement controller: sums coin pulses into credit, runs a req/ack vend
// handshake at PRICE, then pays back leftover or cancelled credit one nickel at a time.
module vending_credit_ctrl #(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    output logic                vend_req,
    input  logic                vend_ack,
    output logic                change_valid,
    input  logic                change_ready,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int unsigned SUM_W = CREDIT_W + 3;
    localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0]    PRICE_S    = SUM_W'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C      = CREDIT_W'(1);

    typedef enum logic [1:0] {
        COLLECT,
        VEND,
        CHANGE
    } state_t;

    state_t           state;
    logic             coin_any;
    logic [3:0]       coin_val;
    logic [SUM_W-1:0] sum;

    // Coin value and prospective credit, wide enough that overflow is visible
    always_comb begin
        coin_any = nickel | dime | quarter;
        coin_val = {3'b000, nickel} + {2'b00, dime, 1'b0} + {1'b0, quarter, 1'b0, quarter};
        sum      = SUM_W'(credit) + SUM_W'(coin_val);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= COLLECT;
            credit       <= '0;
            vend_req     <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel) begin
                        coin_reject <= coin_any;
                        if (credit != '0) begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end else if (coin_any) begin
                        // Coins are all-or-nothing: refuse the whole cycle on overflow
                        if (sum > CREDIT_MAX) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= CREDIT_W'(sum);
                            if (sum >= PRICE_S) begin
                                state    <= VEND;
                                vend_req <= 1'b1;
                                busy     <= 1'b1;
                            end
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_any;
                    if (vend_ack) begin
                        vend_req <= 1'b0;
                        credit   <= credit - PRICE_C;
                        if (credit != PRICE_C) begin
                            state        <= CHANGE;
                            change_valid <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_any;
                    if (change_ready) begin
                        if (credit <= ONE_C) begin
                            credit       <= '0;
                            state        <= COLLECT;
                            change_valid <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            credit <= credit - ONE_C;
                        end
                    end
                end
                default: begin
                    state        <= COLLECT;
                    vend_req     <= 1'b0;
                    change_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Scoreboard bench: each directed row queues its hand-computed next-cycle outputs;
// a monitor pops and compares after every clock edge. Two configurations are exercised.
module tb_vending_credit_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Configuration A: PRICE=4, CREDIT_W=4
    logic       reset_a = 1'b1, nickel_a = 1'b0, dime_a = 1'b0, quarter_a = 1'b0;
    logic       cancel_a = 1'b0, ack_a = 1'b0, ready_a = 1'b0;
    logic       vreq_a, cval_a, crej_a, busy_a;
    logic [3:0] credit_a;

    // Configuration B: PRICE=7, CREDIT_W=3
    logic       reset_b = 1'b1, nickel_b = 1'b0, dime_b = 1'b0, quarter_b = 1'b0;
    logic       cancel_b = 1'b0, ack_b = 1'b0, ready_b = 1'b0;
    logic       vreq_b, cval_b, crej_b, busy_b;
    logic [2:0] credit_b;

    vending_credit_ctrl #(.PRICE(4), .CREDIT_W(4)) dut_a (
        .clock(clock), .reset(reset_a), .nickel(nickel_a), .dime(dime_a),
        .quarter(quarter_a), .cancel(cancel_a), .vend_req(vreq_a), .vend_ack(ack_a),
        .change_valid(cval_a), .change_ready(ready_a), .coin_reject(crej_a),
        .credit(credit_a), .busy(busy_a)
    );

    vending_credit_ctrl #(.PRICE(7), .CREDIT_W(3)) dut_b (
        .clock(clock), .reset(reset_b), .nickel(nickel_b), .dime(dime_b),
        .quarter(quarter_b), .cancel(cancel_b), .vend_req(vreq_b), .vend_ack(ack_b),
        .change_valid(cval_b), .change_ready(ready_b), .coin_reject(crej_b),
        .credit(credit_b), .busy(busy_b)
    );

    // Input row bits {reset, nickel, dime, quarter, cancel, ack, ready}
    localparam logic [6:0] IDLE = 7'b0000000;
    localparam logic [6:0] RST  = 7'b1000000;
    localparam logic [6:0] NIK  = 7'b0100000;
    localparam logic [6:0] DIM  = 7'b0010000;
    localparam logic [6:0] QTR  = 7'b0001000;
    localparam logic [6:0] CAN  = 7'b0000100;
    localparam logic [6:0] ACK  = 7'b0000010;
    localparam logic [6:0] RDY  = 7'b0000001;
    // Expected flag bits {vend_req, change_valid, coin_reject, busy}
    localparam logic [3:0] F0 = 4'b0000;
    localparam logic [3:0] FV = 4'b1001;
    localparam logic [3:0] FC = 4'b0101;
    localparam logic [3:0] FJ = 4'b0010;
    localparam bit SEL_A = 1'b0;
    localparam bit SEL_B = 1'b1;

    typedef struct packed {
        logic       sel;
        logic [3:0] credit;
        logic [3:0] flags;
        logic [15:0] row;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   row_no = 0;
    int   xfers_a = 0, xfers_b = 0, vends_a = 0, vends_b = 0;

    task automatic cyc(input bit sel, input logic [6:0] in,
                       input logic [3:0] ecr, input logic [3:0] efl);
        exp_t e;
        @(negedge clock);
        {nickel_a, dime_a, quarter_a, cancel_a, ack_a, ready_a} = 6'b0;
        {nickel_b, dime_b, quarter_b, cancel_b, ack_b, ready_b} = 6'b0;
        if (sel == SEL_A)
            {reset_a, nickel_a, dime_a, quarter_a, cancel_a, ack_a, ready_a} = in;
        else
            {reset_b, nickel_b, dime_b, quarter_b, cancel_b, ack_b, ready_b} = in;
        row_no++;
        e.sel    = sel;
        e.credit = ecr;
        e.flags  = efl;
        e.row    = 16'(row_no);
        sb.push_back(e);
    endtask

    // Count completed handshakes using values present at the clock edge
    always @(posedge clock) begin
        if (!reset_a && cval_a && ready_a) xfers_a <= xfers_a + 1;
        if (!reset_b && cval_b && ready_b) xfers_b <= xfers_b + 1;
        if (!reset_a && vreq_a && ack_a)   vends_a <= vends_a + 1;
        if (!reset_b && vreq_b && ack_b)   vends_b <= vends_b + 1;
    end

    initial begin : monitor
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == SEL_A) act = {credit_a, vreq_a, cval_a, crej_a, busy_a};
                else                act = {1'b0, credit_b, vreq_b, cval_b, crej_b, busy_b};
                checks++;
                if (act !== {e.credit, e.flags}) begin
                    errors++;
                    $display("FAIL row%0d dut=%s credit=%0d flags(vreq,cval,crej,busy)=%b expected credit=%0d flags=%b",
                             e.row, (e.sel == SEL_A) ? "A" : "B", act[7:4], act[3:0],
                             e.credit, e.flags);
                end
            end
        end
    end

    task automatic check_count(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    initial begin
        // Reset state
        cyc(SEL_A, RST, 4'd0, F0);
        // Four nickels reach price, vend with no change
        cyc(SEL_A, NIK,  4'd1, F0);
        cyc(SEL_A, IDLE, 4'd1, F0);
        cyc(SEL_A, NIK,  4'd2, F0);
        cyc(SEL_A, IDLE, 4'd2, F0);
        cyc(SEL_A, NIK,  4'd3, F0);
        cyc(SEL_A, IDLE, 4'd3, F0);
        cyc(SEL_A, NIK,  4'd4, FV);
        cyc(SEL_A, IDLE, 4'd4, FV);
        cyc(SEL_A, ACK,  4'd0, F0);
        cyc(SEL_A, IDLE, 4'd0, F0);
        // Ack outside VEND ignored; cancel at zero credit rejects coin
        cyc(SEL_A, ACK,       4'd0, F0);
        cyc(SEL_A, CAN | NIK, 4'd0, FJ);
        cyc(SEL_A, IDLE,      4'd0, F0);
        // Quarter overpays by one nickel
        cyc(SEL_A, QTR,  4'd5, FV);
        cyc(SEL_A, ACK,  4'd1, FC);
        cyc(SEL_A, RDY,  4'd0, F0);
        cyc(SEL_A, IDLE, 4'd0, F0);
        // Dime + nickel then cancel, ready toggled
        cyc(SEL_A, DIM,  4'd2, F0);
        cyc(SEL_A, NIK,  4'd3, F0);
        cyc(SEL_A, CAN,  4'd3, FC);
        cyc(SEL_A, RDY,  4'd2, FC);
        cyc(SEL_A, IDLE, 4'd2, FC);
        cyc(SEL_A, RDY,  4'd1, FC);
        cyc(SEL_A, IDLE, 4'd1, FC);
        cyc(SEL_A, RDY,  4'd0, F0);
        cyc(SEL_A, IDLE, 4'd0, F0);
        // Coin added in full on the reaching cycle; dime refused during VEND
        cyc(SEL_A, NIK,  4'd1, F0);
        cyc(SEL_A, QTR,  4'd6, FV);
        cyc(SEL_A, DIM,  4'd6, FV | FJ);
        cyc(SEL_A, IDLE, 4'd6, FV);
        cyc(SEL_A, ACK,  4'd2, FC);
        cyc(SEL_A, RDY,  4'd1, FC);
        cyc(SEL_A, RDY,  4'd0, F0);
        // All three coins in one cycle, coin refused during CHANGE
        cyc(SEL_A, NIK | DIM | QTR, 4'd8, FV);
        cyc(SEL_A, ACK,             4'd4, FC);
        cyc(SEL_A, RDY | NIK,       4'd3, FC | FJ);
        cyc(SEL_A, RDY,             4'd2, FC);
        cyc(SEL_A, RDY,             4'd1, FC);
        cyc(SEL_A, RDY,             4'd0, F0);
        // Reset mid-CHANGE and mid-VEND abandons the transaction
        cyc(SEL_A, DIM,  4'd2, F0);
        cyc(SEL_A, NIK,  4'd3, F0);
        cyc(SEL_A, CAN,  4'd3, FC);
        cyc(SEL_A, RST,  4'd0, F0);
        cyc(SEL_A, NIK,  4'd1, F0);
        cyc(SEL_A, NIK,  4'd2, F0);
        cyc(SEL_A, QTR,  4'd7, FV);
        cyc(SEL_A, RST,  4'd0, F0);
        cyc(SEL_A, IDLE, 4'd0, F0);

        // Configuration B: overflow refusal, cancel with coin, exact-max vend
        cyc(SEL_B, RST,       4'd0, F0);
        cyc(SEL_B, QTR,       4'd5, F0);
        cyc(SEL_B, NIK,       4'd6, F0);
        cyc(SEL_B, QTR,       4'd6, FJ);
        cyc(SEL_B, IDLE,      4'd6, F0);
        cyc(SEL_B, CAN | NIK, 4'd6, FC | FJ);
        cyc(SEL_B, RDY,       4'd5, FC);
        cyc(SEL_B, RDY,       4'd4, FC);
        cyc(SEL_B, RDY,       4'd3, FC);
        cyc(SEL_B, RDY,       4'd2, FC);
        cyc(SEL_B, RDY,       4'd1, FC);
        cyc(SEL_B, RDY,       4'd0, F0);
        cyc(SEL_B, DIM,       4'd2, F0);
        cyc(SEL_B, QTR,       4'd7, FV);
        cyc(SEL_B, ACK,       4'd0, F0);
        cyc(SEL_B, IDLE,      4'd0, F0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        @(negedge clock);
        check_count("xfers_a", xfers_a, 10);
        check_count("vends_a", vends_a, 4);
        check_count("xfers_b", xfers_b, 6);
        check_count("vends_b", vends_b, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
